// File: rtl/ising_weight_ctrl.sv
// ising_weight_ctrl
//   AXI4-Lite slave sitting directly upstream of the NxN coupled_cell array.
//   - Decodes weight writes into a single-cycle broadcast strobe
//     (cell_wready / cell_wr_match / cell_wdata).
//   - Muxes per-cell weight readback onto the AXI read channel.
//   - Owns ising_rstn: 0 holds the oscillators in spin-programming mode,
//     1 lets them run, optionally for a programmed number of cycles.
// Ports
//   clk, axi_rst              clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*           AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                AXI4-Lite read address/data channels
//   cell_wready               broadcast write strobe to all cells
//   cell_wr_match             one-hot cell select (bit k = cell k)
//   cell_wdata                broadcast write data
//   cell_rdata                flattened cell weights, cell k at [k*W +: W]
//   ising_rstn                1 = oscillators run, 0 = program/hold
//   run_done                  one-cycle pulse when a timed run expires
// Register map (byte addresses, addr[1:0] ignored)
//   0x00 CTRL     W bit0 start(1)/abort(0); R bit0 running
//   0x04 STATUS   R bit0 running, bit1 done; writes ignored
//   0x08 TIMER    RW run length in cycles (0 = run until aborted)
//   WEIGHT_BASE+4k  RW weight of cell k (low W bits)
//   anything else -> SLVERR, no write effect, reads return 0
module ising_weight_ctrl #(
  parameter int unsigned N           = 4,
  parameter int unsigned NUM_WEIGHTS = 15,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WEIGHT_BASE = 'h100
) (
  input  logic                                  clk,
  input  logic                                  axi_rst,
  input  logic [ADDR_W-1:0]                     s_awaddr,
  input  logic                                  s_awvalid,
  output logic                                  s_awready,
  input  logic [31:0]                           s_wdata,
  input  logic                                  s_wvalid,
  output logic                                  s_wready,
  output logic [1:0]                            s_bresp,
  output logic                                  s_bvalid,
  input  logic                                  s_bready,
  input  logic [ADDR_W-1:0]                     s_araddr,
  input  logic                                  s_arvalid,
  output logic                                  s_arready,
  output logic [31:0]                           s_rdata,
  output logic [1:0]                            s_rresp,
  output logic                                  s_rvalid,
  input  logic                                  s_rready,
  output logic                                  cell_wready,
  output logic [N*N-1:0]                        cell_wr_match,
  output logic [31:0]                           cell_wdata,
  input  logic [N*N*$clog2(NUM_WEIGHTS)-1:0]    cell_rdata,
  output logic                                  ising_rstn,
  output logic                                  run_done
);

  localparam int unsigned W      = $clog2(NUM_WEIGHTS);
  localparam int unsigned CELLS  = N * N;
  localparam int unsigned IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] BASE_WORD = WORD_W'(WEIGHT_BASE >> 2);
  localparam logic [WORD_W-1:0] BASE_END  = WORD_W'((WEIGHT_BASE >> 2) + CELLS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_CTRL, REG_STATUS, REG_TIMER, REG_WEIGHT, REG_BAD
  } region_e;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  // Word address -> register region; fixed registers win over the weight window.
  function automatic region_e decode(input logic [WORD_W-1:0] word);
    region_e r;
    if (word == WORD_W'(0))                         r = REG_CTRL;
    else if (word == WORD_W'(1))                    r = REG_STATUS;
    else if (word == WORD_W'(2))                    r = REG_TIMER;
    else if (word >= BASE_WORD && word < BASE_END)  r = REG_WEIGHT;
    else                                            r = REG_BAD;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] cell_index(input logic [WORD_W-1:0] word);
    return IDX_W'(word - BASE_WORD);
  endfunction

  // Byte-lane bits are don't-care in this register map.
  logic unused_lane_bits;
  assign unused_lane_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Run-control state
  logic [31:0] timer_q;
  logic [31:0] cnt;
  logic        timed;
  logic        running;
  logic        done;

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  w_state_e            w_state, w_state_n;
  logic                aw_have, aw_have_n;
  logic                w_have, w_have_n;
  logic [WORD_W-1:0]   aw_word_q, aw_word_n;
  logic [31:0]         wdata_q, wdata_n;
  logic                awready_n, wready_n, bvalid_n;
  logic [1:0]          bresp_n;
  logic                cell_wready_n;
  logic [N*N-1:0]      cell_wr_match_n;
  logic [31:0]         cell_wdata_n;

  // Write state, held AW/W payload and all write-side outputs
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      w_state       <= W_IDLE;
      aw_have       <= 1'b0;
      w_have        <= 1'b0;
      aw_word_q     <= '0;
      wdata_q       <= '0;
      s_awready     <= 1'b0;
      s_wready      <= 1'b0;
      s_bvalid      <= 1'b0;
      s_bresp       <= RESP_OKAY;
      cell_wready   <= 1'b0;
      cell_wr_match <= '0;
      cell_wdata    <= '0;
    end else begin
      w_state       <= w_state_n;
      aw_have       <= aw_have_n;
      w_have        <= w_have_n;
      aw_word_q     <= aw_word_n;
      wdata_q       <= wdata_n;
      s_awready     <= awready_n;
      s_wready      <= wready_n;
      s_bvalid      <= bvalid_n;
      s_bresp       <= bresp_n;
      cell_wready   <= cell_wready_n;
      cell_wr_match <= cell_wr_match_n;
      cell_wdata    <= cell_wdata_n;
    end
  end

  // Write next-state: strobes are computed on entry so they are live exactly in W_COMMIT
  always_comb begin
    w_state_n       = w_state;
    aw_have_n       = aw_have;
    w_have_n        = w_have;
    aw_word_n       = aw_word_q;
    wdata_n         = wdata_q;
    awready_n       = s_awready;
    wready_n        = s_wready;
    bvalid_n        = s_bvalid;
    bresp_n         = s_bresp;
    cell_wready_n   = 1'b0;
    cell_wr_match_n = '0;
    cell_wdata_n    = '0;

    case (w_state)
      W_IDLE: begin
        if (s_awvalid && s_awready) begin
          aw_word_n = s_awaddr[ADDR_W-1:2];
          aw_have_n = 1'b1;
        end
        if (s_wvalid && s_wready) begin
          wdata_n  = s_wdata;
          w_have_n = 1'b1;
        end
        awready_n = !aw_have_n;
        wready_n  = !w_have_n;
        if (aw_have_n && w_have_n) begin
          w_state_n = W_COMMIT;
          if (decode(aw_word_n) == REG_WEIGHT) begin
            cell_wready_n                         = 1'b1;
            cell_wr_match_n[cell_index(aw_word_n)] = 1'b1;
            cell_wdata_n                          = wdata_n;
          end
        end
      end
      W_COMMIT: begin
        aw_have_n = 1'b0;
        w_have_n  = 1'b0;
        bvalid_n  = 1'b1;
        bresp_n   = (decode(aw_word_q) == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
        w_state_n = W_RESP;
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Register-side effects of the commit cycle
  logic ctrl_commit;
  logic timer_commit;
  assign ctrl_commit  = (w_state == W_COMMIT) && (decode(aw_word_q) == REG_CTRL);
  assign timer_commit = (w_state == W_COMMIT) && (decode(aw_word_q) == REG_TIMER);

  // ---------------------------------------------------------------------
  // Run timer. 'timed' latches TIMER!=0 at start so mid-run TIMER writes
  // only affect the next start.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      timer_q  <= '0;
      cnt      <= '0;
      timed    <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      run_done <= 1'b0;
    end else begin
      run_done <= 1'b0;
      if (timer_commit) begin
        timer_q <= wdata_q;
      end
      if (ctrl_commit) begin
        if (wdata_q[0]) begin
          running <= 1'b1;
          cnt     <= timer_q;
          timed   <= (timer_q != 32'd0);
          done    <= 1'b0;
        end else begin
          running <= 1'b0;
        end
      end else if (running && timed) begin
        if (cnt == 32'd1) begin
          running  <= 1'b0;
          done     <= 1'b1;
          run_done <= 1'b1;
        end else begin
          cnt <= cnt - 32'd1;
        end
      end
    end
  end

  assign ising_rstn = running;

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  r_state_e            r_state, r_state_n;
  logic [WORD_W-1:0]   ar_word_q, ar_word_n;
  logic                arready_n, rvalid_n;
  logic [31:0]         rdata_n;
  logic [1:0]          rresp_n;
  logic [31:0]         rd_value;
  logic                rd_err;
  logic [W-1:0]        rd_weight;

  // Read data mux over the captured address
  always_comb begin
    rd_value  = '0;
    rd_err    = 1'b0;
    rd_weight = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (cell_index(ar_word_q) == IDX_W'(k)) rd_weight = cell_rdata[k*W +: W];
    end
    case (decode(ar_word_q))
      REG_CTRL:   rd_value = {31'd0, running};
      REG_STATUS: rd_value = {30'd0, done, running};
      REG_TIMER:  rd_value = timer_q;
      REG_WEIGHT: rd_value = 32'(rd_weight);
      default:    rd_err   = 1'b1;
    endcase
  end

  // Read state, captured address and read-side outputs
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      r_state   <= R_IDLE;
      ar_word_q <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      r_state   <= r_state_n;
      ar_word_q <= ar_word_n;
      s_arready <= arready_n;
      s_rvalid  <= rvalid_n;
      s_rdata   <= rdata_n;
      s_rresp   <= rresp_n;
    end
  end

  // Read next-state: capture address, sample data one edge later, hold until rready
  always_comb begin
    r_state_n = r_state;
    ar_word_n = ar_word_q;
    arready_n = s_arready;
    rvalid_n  = s_rvalid;
    rdata_n   = s_rdata;
    rresp_n   = s_rresp;

    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (s_arvalid && s_arready) begin
          ar_word_n = s_araddr[ADDR_W-1:2];
          arready_n = 1'b0;
          r_state_n = R_ADDR;
        end
      end
      R_ADDR: begin
        rvalid_n  = 1'b1;
        rdata_n   = rd_value;
        rresp_n   = rd_err ? RESP_SLVERR : RESP_OKAY;
        r_state_n = R_DATA;
      end
      R_DATA: begin
        if (s_rready) begin
          rvalid_n  = 1'b0;
          rdata_n   = '0;
          rresp_n   = RESP_OKAY;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ising_weight_ctrl.sv
// Directed + randomized-traffic bench for ising_weight_ctrl with a
// behavioural model of the 4x4 cell array hooked to the weight ports.
module tb_ising_weight_ctrl;

  logic        clk;
  logic        axi_rst;
  logic [11:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        cell_wready;
  logic [15:0] cell_wr_match;
  logic [31:0] cell_wdata;
  logic [63:0] cell_rdata;
  logic        ising_rstn;
  logic        run_done;

  int vecs;
  int errs;

  logic [3:0]  cells [16];
  logic [3:0]  exp_w [16];
  logic [31:0] exp_timer;

  int rstn_cycles;
  int done_pulses;
  int wr_pulses;

  ising_weight_ctrl dut (
    .clk(clk), .axi_rst(axi_rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cell_wready(cell_wready), .cell_wr_match(cell_wr_match), .cell_wdata(cell_wdata),
    .cell_rdata(cell_rdata), .ising_rstn(ising_rstn), .run_done(run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array model: weights latch on the broadcast strobe
  always @(posedge clk) begin
    if (cell_wready) begin
      for (int k = 0; k < 16; k++) if (cell_wr_match[k]) cells[k] <= cell_wdata[3:0];
    end
  end

  always_comb begin
    cell_rdata = '0;
    for (int k = 0; k < 16; k++) cell_rdata[k*4 +: 4] = cells[k];
  end

  always @(negedge clk) begin
    if (ising_rstn)  rstn_cycles++;
    if (run_done)    done_pulses++;
    if (cell_wready) wr_pulses++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0; n = 0; ok = 1; resp = 2'b11;
    s_awaddr = addr; s_wdata = data;
    while (!(aw_done && w_done) && n < 200) begin
      s_awvalid = !aw_done && (n >= aw_dly);
      s_wvalid  = !w_done && (n >= w_dly);
      hs_aw = s_awvalid && s_awready;
      hs_w  = s_wvalid && s_wready;
      step(); n++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) ok = 0;
    n = 0;
    while (n < 200) begin
      s_bready = (n >= b_dly);
      if (s_bvalid && s_bready) begin
        resp = s_bresp;
        break;
      end
      step(); n++;
    end
    if (n >= 200) ok = 0;
    else step();
    s_bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit ar_done, hs;
    int n;
    ar_done = 0; n = 0; ok = 1; data = 32'hDEADBEEF; resp = 2'b11;
    s_araddr = addr;
    while (!ar_done && n < 200) begin
      s_arvalid = (n >= ar_dly);
      hs = s_arvalid && s_arready;
      step(); n++;
      if (hs) ar_done = 1;
    end
    s_arvalid = 0;
    if (!ar_done) ok = 0;
    n = 0;
    while (n < 200) begin
      s_rready = (n >= r_dly);
      if (s_rvalid && s_rready) begin
        data = s_rdata;
        resp = s_rresp;
        break;
      end
      step(); n++;
    end
    if (n >= 200) ok = 0;
    else step();
    s_rready = 0;
  endtask

  task automatic test_reset();
    axi_rst = 1;
    step(2);
    vecs++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cell_wready, ising_rstn, run_done} !== 8'd0 ||
        cell_wr_match !== 16'd0 || cell_wdata !== 32'd0 || s_rdata !== 32'd0 ||
        s_bresp !== 2'd0 || s_rresp !== 2'd0) begin
      errs++;
      $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b bvalid=%b rvalid=%b cwr=%b rstn=%b done=%b, all required 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cell_wready, ising_rstn, run_done);
    end
    axi_rst = 0;
    step();
    vecs++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errs++;
      $display("FAIL reset_ready_rise: aw/w/ar_ready=%b%b%b, required 111", s_awready, s_wready, s_arready);
    end
  endtask

  task automatic test_weight_write();
    wr_pulses = 0;
    s_awaddr = 12'h114; s_awvalid = 1;
    step();
    s_awvalid = 0;
    step();
    s_wdata = 32'd7; s_wvalid = 1;
    vecs++;
    if (cell_wready !== 1'b0) begin
      errs++; $display("FAIL ww_early_strobe: cell_wready=%b before W, required 0", cell_wready);
    end
    step();
    s_wvalid = 0;
    vecs++;
    if (cell_wready !== 1'b1 || cell_wr_match !== 16'h0020 || cell_wdata !== 32'd7 || s_bvalid !== 1'b0) begin
      errs++;
      $display("FAIL ww_commit: cwr=%b match=%h wdata=%0d bvalid=%b, required 1 0020 7 0",
               cell_wready, cell_wr_match, cell_wdata, s_bvalid);
    end
    step();
    vecs++;
    if (cell_wready !== 1'b0 || cell_wr_match !== 16'h0 || s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errs++;
      $display("FAIL ww_resp: cwr=%b match=%h bvalid=%b bresp=%b, required 0 0000 1 00",
               cell_wready, cell_wr_match, s_bvalid, s_bresp);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (s_bvalid !== 1'b1) begin
        errs++; $display("FAIL ww_bvalid_hold%0d: bvalid=%b, required 1", i, s_bvalid);
      end
    end
    s_bready = 1;
    step();
    s_bready = 0;
    vecs++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || wr_pulses !== 1) begin
      errs++;
      $display("FAIL ww_done: bvalid=%b awready=%b strobes=%0d, required 0 1 1", s_bvalid, s_awready, wr_pulses);
    end
    exp_w[5] = 4'd7;
  endtask

  task automatic test_readback();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_read(12'h114, 0, 2, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd7 || r !== 2'b00) begin
      errs++; $display("FAIL rd_cell5: ok=%b rdata=%0d rresp=%b, required 1 7 00", ok, d, r);
    end
    axi_read(12'h200, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd0 || r !== 2'b10) begin
      errs++; $display("FAIL rd_bad: ok=%b rdata=%0d rresp=%b, required 1 0 10", ok, d, r);
    end
    axi_write(12'h200, 32'h5, 0, 0, 0, r, ok);
    vecs++;
    if (!ok || r !== 2'b10) begin
      errs++; $display("FAIL wr_bad: ok=%b bresp=%b, required 1 10", ok, r);
    end
    axi_read(12'h000, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd0 || r !== 2'b00) begin
      errs++; $display("FAIL rd_ctrl_idle: ok=%b rdata=%0d rresp=%b, required 1 0 00", ok, d, r);
    end
  endtask

  task automatic test_timed_run();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(12'h008, 32'd10, 0, 0, 0, r, ok);
    axi_read(12'h008, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd10) begin
      errs++; $display("FAIL timer_rb: rdata=%0d, required 10", d);
    end
    rstn_cycles = 0; done_pulses = 0;
    axi_write(12'h000, 32'd1, 0, 0, 0, r, ok);
    step(30);
    vecs++;
    if (rstn_cycles !== 10 || done_pulses !== 1 || ising_rstn !== 1'b0) begin
      errs++;
      $display("FAIL run10: high=%0d pulses=%0d rstn=%b, required 10 1 0", rstn_cycles, done_pulses, ising_rstn);
    end
    axi_read(12'h004, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd2) begin
      errs++; $display("FAIL status_done: rdata=%0d, required 2", d);
    end
    axi_write(12'h008, 32'd1, 0, 0, 0, r, ok);
    rstn_cycles = 0; done_pulses = 0;
    axi_write(12'h000, 32'd1, 0, 0, 0, r, ok);
    step(10);
    vecs++;
    if (rstn_cycles !== 1 || done_pulses !== 1) begin
      errs++; $display("FAIL run1: high=%0d pulses=%0d, required 1 1", rstn_cycles, done_pulses);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(12'h008, 32'd100, 0, 0, 0, r, ok);
    done_pulses = 0;
    axi_write(12'h000, 32'd1, 0, 0, 0, r, ok);
    step(20);
    vecs++;
    if (ising_rstn !== 1'b1) begin
      errs++; $display("FAIL abort_running: rstn=%b, required 1", ising_rstn);
    end
    axi_write(12'h000, 32'd0, 0, 0, 0, r, ok);
    step(150);
    vecs++;
    if (ising_rstn !== 1'b0 || done_pulses !== 0) begin
      errs++; $display("FAIL abort_stop: rstn=%b pulses=%0d, required 0 0", ising_rstn, done_pulses);
    end
    axi_read(12'h004, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd0) begin
      errs++; $display("FAIL abort_status: rdata=%0d, required 0", d);
    end
  endtask

  task automatic test_untimed_run();
    logic [1:0] r; bit ok;
    axi_write(12'h008, 32'd0, 0, 0, 0, r, ok);
    done_pulses = 0;
    axi_write(12'h000, 32'd1, 0, 0, 0, r, ok);
    step(200);
    vecs++;
    if (ising_rstn !== 1'b1 || done_pulses !== 0) begin
      errs++; $display("FAIL untimed: rstn=%b pulses=%0d, required 1 0", ising_rstn, done_pulses);
    end
    axi_write(12'h000, 32'd0, 0, 0, 0, r, ok);
    step(2);
    vecs++;
    if (ising_rstn !== 1'b0) begin
      errs++; $display("FAIL untimed_abort: rstn=%b, required 0", ising_rstn);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, rd; logic [1:0] r, br; bit got_r, got_b, ok;
    got_r = 0; got_b = 0; rd = 32'hDEADBEEF; br = 2'b11;
    s_awaddr = 12'h100; s_wdata = 32'd3; s_araddr = 12'h100;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    s_bready = 1; s_rready = 1;
    for (int i = 0; i < 10; i++) begin
      if (s_rvalid && !got_r) begin rd = s_rdata; got_r = 1; end
      if (s_bvalid && !got_b) begin br = s_bresp; got_b = 1; end
      step();
    end
    s_bready = 0; s_rready = 0;
    vecs++;
    if (!got_r || rd !== 32'd0) begin
      errs++; $display("FAIL b2b_read_old: got=%b rdata=%0d, required 1 0", got_r, rd);
    end
    vecs++;
    if (!got_b || br !== 2'b00) begin
      errs++; $display("FAIL b2b_write: got=%b bresp=%b, required 1 00", got_b, br);
    end
    exp_w[0] = 4'd3;
    axi_read(12'h100, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd3) begin
      errs++; $display("FAIL b2b_read_new: rdata=%0d, required 3", d);
    end
  endtask

  task automatic test_random_traffic();
    logic [31:0] d, ev; logic [1:0] r, er; logic [11:0] a; bit ok;
    int kind, k;
    for (int i = 0; i < 1000; i++) begin
      kind = $urandom_range(0, 3);
      k    = $urandom_range(0, 15);
      case (kind)
        0:       a = 12'h100 + 12'(4 * k);
        1:       a = 12'h008;
        2:       a = 12'h004;
        default: a = ($urandom_range(0, 1) == 0) ? 12'h200 : 12'h00C;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      er = (kind == 3) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
        if (kind == 0) exp_w[k] = d[3:0];
        if (kind == 1) exp_timer = d;
        vecs++;
        if (!ok || r !== er) begin
          errs++; $display("FAIL rnd_wr%0d addr=%h: ok=%b bresp=%b, required 1 %b", i, a, ok, r, er);
        end
      end else begin
        case (kind)
          0:       ev = 32'(exp_w[k]);
          1:       ev = exp_timer;
          default: ev = 32'd0;
        endcase
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r, ok);
        vecs++;
        if (!ok || d !== ev || r !== er) begin
          errs++;
          $display("FAIL rnd_rd%0d addr=%h: ok=%b rdata=%h rresp=%b, required 1 %h %b", i, a, ok, d, r, ev, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(12'h008, 32'd55, 0, 0, 0, r, ok);
    axi_write(12'h000, 32'd1, 0, 0, 0, r, ok);
    step(5);
    axi_rst = 1;
    step();
    vecs++;
    if (ising_rstn !== 1'b0 || s_awready !== 1'b0 || s_arready !== 1'b0) begin
      errs++;
      $display("FAIL midrun_reset: rstn=%b awready=%b arready=%b, required 0 0 0", ising_rstn, s_awready, s_arready);
    end
    axi_rst = 0;
    step();
    axi_read(12'h008, 0, 0, d, r, ok);
    vecs++;
    if (!ok || d !== 32'd0) begin
      errs++; $display("FAIL midrun_timer_clr: rdata=%0d, required 0", d);
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rstn_cycles = 0; done_pulses = 0; wr_pulses = 0;
    exp_timer = 32'd0;
    for (int k = 0; k < 16; k++) begin
      cells[k] = 4'd0;
      exp_w[k] = 4'd0;
    end
    axi_rst = 1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    #1;
    test_reset();
    test_weight_write();
    test_readback();
    test_timed_run();
    test_abort();
    test_untimed_run();
    test_back_to_back();
    test_random_traffic();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
